// File: rtl/adc_pkg.sv
// Shared types and default sizing for the ADC tap line.
package adc_pkg;
  localparam int ADC_IN_W  = 12;
  localparam int ADC_TAP_W = 36;
  localparam int ADC_DEPTH = 16;

  typedef enum logic [1:0] {
    EMPTY,
    FILL,
    FULL
  } tap_state_t;
endpackage

// File: rtl/adc_decim_cnt.sv
// Keep-1-of-DECIM phase counter; fire marks a tick that lands on phase 0.
module adc_decim_cnt #(
  parameter int DECIM = 1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic tick,
  output logic fire
);
  localparam int CW = (DECIM > 1) ? $clog2(DECIM) : 1;

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (tick) begin
      cnt_d = (cnt_q == CW'(DECIM - 1)) ? '0 : cnt_q + 1'b1;
    end
  end

  assign fire = tick && (cnt_q == '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: rtl/adc_tap_line.sv
// Decimating shift line of sign-extended ADC samples; taps[0] newest.
module adc_tap_line
  import adc_pkg::*;
#(
  parameter int IN_W  = ADC_IN_W,
  parameter int WIDTH = ADC_TAP_W,
  parameter int DEPTH = ADC_DEPTH,
  parameter int DECIM = 1
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic                               flush,
  input  logic                               in_valid,
  input  logic signed [IN_W-1:0]             adc_in,
  output logic        [DEPTH-1:0][WIDTH-1:0] taps,
  output logic                               taps_valid,
  output logic                               tap_strobe,
  output logic        [$clog2(DEPTH+1)-1:0]  fill_count,
  output tap_state_t                         state_dbg
);
  localparam int FW = $clog2(DEPTH + 1);

  // in_valid only qualifies adc_in; there is no back-pressure, every
  // qualified sample on decimation phase 0 is taken that cycle.
  logic                        accept;
  logic [WIDTH-1:0]            sample;
  logic [DEPTH-1:0][WIDTH-1:0] taps_q, taps_d;
  logic [FW-1:0]               fill_q, fill_d;
  logic                        strobe_q, strobe_d;
  tap_state_t                  state_q, state_d;

  adc_decim_cnt #(.DECIM(DECIM)) u_decim (
    .clk  (clk),
    .rst_n(rst_n),
    .clr  (flush),
    .tick (in_valid && !flush),
    .fire (accept)
  );

  assign sample = WIDTH'(adc_in);

  always_comb begin
    taps_d   = taps_q;
    fill_d   = fill_q;
    strobe_d = accept;
    state_d  = state_q;
    if (flush) begin
      taps_d  = '0;
      fill_d  = '0;
      state_d = EMPTY;
    end else if (accept) begin
      taps_d = {taps_q[DEPTH-2:0], sample};
      if (fill_q != FW'(DEPTH)) fill_d = fill_q + 1'b1;
      case (state_q)
        EMPTY:   state_d = FILL;
        FILL:    state_d = (fill_q == FW'(DEPTH - 1)) ? FULL : FILL;
        FULL:    state_d = FULL;
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      taps_q   <= '0;
      fill_q   <= '0;
      strobe_q <= 1'b0;
      state_q  <= EMPTY;
    end else begin
      taps_q   <= taps_d;
      fill_q   <= fill_d;
      strobe_q <= strobe_d;
      state_q  <= state_d;
    end
  end

  assign taps       = taps_q;
  assign fill_count = fill_q;
  assign tap_strobe = strobe_q;
  assign taps_valid = (state_q == FULL);
  assign state_dbg  = state_q;
endmodule

// File: tb/tb_adc_tap_line.sv
// Directed bench for adc_tap_line: fill, sign extension, decimation, flush, reset.
module tb_adc_tap_line;
  import adc_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  logic               flush = 1'b0, in_valid = 1'b0;
  logic [11:0]        adc_in = '0;
  logic [15:0][35:0]  taps;
  logic               taps_valid, tap_strobe;
  logic [4:0]         fill_count;
  tap_state_t         state_dbg;

  logic               flush3 = 1'b0, in_valid3 = 1'b0;
  logic [11:0]        adc_in3 = '0;
  logic [15:0][35:0]  taps3;
  logic               taps_valid3, tap_strobe3;
  logic [4:0]         fill_count3;
  tap_state_t         state_dbg3;

  int n_vec = 0;
  int n_err = 0;
  int n_strobe;
  logic [35:0] exp_taps [16];

  always #5 clk = ~clk;

  adc_tap_line dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .adc_in(adc_in),
    .taps(taps), .taps_valid(taps_valid), .tap_strobe(tap_strobe),
    .fill_count(fill_count), .state_dbg(state_dbg)
  );

  adc_tap_line #(.DECIM(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .flush(flush3), .in_valid(in_valid3), .adc_in(adc_in3),
    .taps(taps3), .taps_valid(taps_valid3), .tap_strobe(tap_strobe3),
    .fill_count(fill_count3), .state_dbg(state_dbg3)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Called at a negedge; applies inputs across one rising edge, returns at the next negedge.
  task automatic drive(input logic v, input logic [11:0] d, input logic f);
    in_valid = v;
    adc_in   = d;
    flush    = f;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    flush    = 1'b0;
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check("rst_fill", 64'(fill_count), 64'd0);
    check("rst_valid", 64'(taps_valid), 64'd0);
    check("rst_strobe", 64'(tap_strobe), 64'd0);
    check("rst_tap0", 64'(taps[0]), 64'd0);
    check("rst_state", 64'(state_dbg), 64'(EMPTY));
    rst_n = 1'b1;
    @(negedge clk);

    // Decimate by 3, in_valid held high, samples 0..8
    for (int k = 0; k < 9; k++) begin
      in_valid3 = 1'b1;
      adc_in3   = 12'(k);
      @(posedge clk);
      @(negedge clk);
      check("dec_strobe", 64'(tap_strobe3), 64'((k % 3) == 0));
    end
    in_valid3 = 1'b0;
    check("dec_tap0", 64'(taps3[0]), 64'd6);
    check("dec_tap1", 64'(taps3[1]), 64'd3);
    check("dec_tap2", 64'(taps3[2]), 64'd0);
    check("dec_fill", 64'(fill_count3), 64'd3);

    // Fill with 1..16
    n_strobe = 0;
    for (int i = 1; i <= 16; i++) begin
      drive(1'b1, 12'(i), 1'b0);
      if (tap_strobe) n_strobe++;
      check("fill_count", 64'(fill_count), 64'(i));
      check("fill_valid", 64'(taps_valid), 64'(i == 16));
    end
    drive(1'b0, 12'd0, 1'b0);
    if (tap_strobe) n_strobe++;
    check("fill_strobes", 64'(n_strobe), 64'd16);
    check("fill_state", 64'(state_dbg), 64'(FULL));
    for (int i = 0; i < 16; i++) begin
      exp_taps[i] = 36'(16 - i);
      check("fill_tap", 64'(taps[i]), 64'(exp_taps[i]));
    end

    // Random in_valid gaps while FULL
    for (int c = 0; c < 24; c++) begin
      logic v;
      logic [11:0] d;
      v = 1'($urandom_range(0, 1));
      d = 12'($urandom_range(0, 4095));
      drive(v, d, 1'b0);
      if (v) begin
        for (int i = 15; i > 0; i--) exp_taps[i] = exp_taps[i-1];
        exp_taps[0] = {{24{d[11]}}, d};
      end
      check("gap_strobe", 64'(tap_strobe), 64'(v));
      check("gap_fill", 64'(fill_count), 64'd16);
      check("gap_tap0", 64'(taps[0]), 64'(exp_taps[0]));
    end
    for (int i = 0; i < 16; i++) check("gap_tap", 64'(taps[i]), 64'(exp_taps[i]));

    // Extreme values sign-extend exactly
    drive(1'b1, 12'h800, 1'b0);
    drive(1'b1, 12'h7FF, 1'b0);
    check("ext_tap1", 64'(taps[1]), 64'h0000_000F_FFFF_F800);
    check("ext_tap0", 64'(taps[0]), 64'h0000_0000_0000_07FF);

    // Flush with a coincident sample while FULL
    drive(1'b1, 12'd123, 1'b1);
    check("flush_taps", 64'(|taps), 64'd0);
    check("flush_fill", 64'(fill_count), 64'd0);
    check("flush_valid", 64'(taps_valid), 64'd0);
    check("flush_strobe", 64'(tap_strobe), 64'd0);
    check("flush_state", 64'(state_dbg), 64'(EMPTY));
    drive(1'b1, 12'd55, 1'b0);
    check("postflush_fill", 64'(fill_count), 64'd1);
    check("postflush_tap0", 64'(taps[0]), 64'd55);
    check("postflush_tap1", 64'(taps[1]), 64'd0);

    // Asynchronous reset between edges after 5 accepts
    for (int i = 0; i < 4; i++) drive(1'b1, 12'(200 + i), 1'b0);
    check("prerst_fill", 64'(fill_count), 64'd5);
    check("prerst_strobe", 64'(tap_strobe), 64'd1);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_fill", 64'(fill_count), 64'd0);
    check("arst_tap0", 64'(taps[0]), 64'd0);
    check("arst_strobe", 64'(tap_strobe), 64'd0);
    check("arst_state", 64'(state_dbg), 64'(EMPTY));
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    drive(1'b1, 12'd77, 1'b0);
    check("postrst_fill", 64'(fill_count), 64'd1);
    check("postrst_tap0", 64'(taps[0]), 64'd77);
    check("postrst_tap1", 64'(taps[1]), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
